// File: rtl/grant_burst_ctrl.sv
// Burst transfer controller: locks onto an upstream arbiter grant and streams
// BURST_LEN beats from the granted channel, with timeout and request-drop abort.
module grant_burst_ctrl #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int TO_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [1:0]    gnt_idx,
  input  logic          gnt_vld,
  input  logic [DW-1:0] ch_data0,
  input  logic [DW-1:0] ch_data1,
  input  logic [DW-1:0] ch_data2,
  input  logic [DW-1:0] ch_data3,
  input  logic          out_rdy,
  output logic          arb_ena,
  output logic [3:0]    ack,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_ch,
  output logic          out_last,
  output logic          busy,
  output logic          abort,
  output logic [7:0]    done_cnt
);

  typedef enum logic [1:0] {IDLE, LOCK, XFER, DONE} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [7:0] TO_LAST   = 8'(TO_CYCLES - 1);

  state_t        state;
  logic [1:0]    cur_idx;
  logic [4:0]    beat_cnt;
  logic [7:0]    to_cnt;
  logic [DW-1:0] sel_data;
  logic          beat_ok;

  always_comb begin
    sel_data = '0;
    case (cur_idx)
      2'd0: sel_data = ch_data0;
      2'd1: sel_data = ch_data1;
      2'd2: sel_data = ch_data2;
      2'd3: sel_data = ch_data3;
      default: sel_data = '0;
    endcase
  end

  // out_vld is a registered copy of "state == XFER"; beat handshake is combinational
  always_comb begin
    beat_ok  = out_vld & out_rdy;
    out_last = out_vld & (beat_cnt == LAST_BEAT);
    ack      = beat_ok ? (4'b0001 << cur_idx) : 4'b0000;
    out_data = out_vld ? sel_data : '0;
    out_ch   = cur_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_idx  <= '0;
      beat_cnt <= '0;
      to_cnt   <= '0;
      done_cnt <= '0;
      arb_ena  <= 1'b1;
      busy     <= 1'b0;
      out_vld  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld && req[gnt_idx]) begin
            cur_idx <= gnt_idx;
            state   <= LOCK;
            arb_ena <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOCK: begin
          beat_cnt <= '0;
          to_cnt   <= '0;
          out_vld  <= 1'b1;
          state    <= XFER;
        end
        XFER: begin
          // accepted beat wins over request drop and timeout in the same cycle
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 5'd1;
            to_cnt   <= '0;
            if (beat_cnt == LAST_BEAT) begin
              state    <= DONE;
              out_vld  <= 1'b0;
              done_cnt <= done_cnt + 8'd1;
            end
          end else if (!req[cur_idx] || to_cnt == TO_LAST) begin
            state   <= DONE;
            out_vld <= 1'b0;
            abort   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          arb_ena <= 1'b1;
          busy    <= 1'b0;
          abort   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Randomized bench for grant_burst_ctrl against a burst-level behavioural model.
module tb_grant_burst_ctrl;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [1:0]    gnt_idx;
  logic          gnt_vld;
  logic [DW-1:0] d [4];
  logic          out_rdy;
  logic          arb_ena;
  logic [3:0]    ack;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_last;
  logic          busy;
  logic          abort;
  logic [7:0]    done_cnt;

  grant_burst_ctrl #(.DW(DW), .BURST_LEN(BL), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .ch_data0(d[0]), .ch_data1(d[1]), .ch_data2(d[2]), .ch_data3(d[3]),
    .out_rdy(out_rdy), .arb_ena(arb_ena), .ack(ack), .out_vld(out_vld),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy),
    .abort(abort), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a burst is "owned" from grant until its finishing cycle.
  bit m_busy;      // a burst owns the controller
  bit m_lock;      // first cycle after the grant, no beats yet
  int m_fin;       // 0 = still transferring, 1 = finishing normally, 2 = finishing aborted
  int m_beats;     // beats accepted so far in this burst
  int m_low;       // consecutive not-ready cycles while transferring
  int m_ch;
  int m_done;

  task automatic model_reset();
    m_busy = 0; m_lock = 0; m_fin = 0; m_beats = 0; m_low = 0; m_ch = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    bit xf;
    xf = m_busy && !m_lock && m_fin == 0;
    chk("arb_ena",  32'(arb_ena),  32'(!m_busy));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("out_vld",  32'(out_vld),  32'(xf));
    chk("out_last", 32'(out_last), 32'(xf && m_beats == BL - 1));
    chk("ack",      32'(ack),      (xf && out_rdy) ? (32'd1 << m_ch) : 32'd0);
    chk("out_data", 32'(out_data), xf ? 32'(d[m_ch]) : 32'd0);
    chk("out_ch",   32'(out_ch),   32'(m_ch));
    chk("abort",    32'(abort),    32'(m_fin == 2));
    chk("done_cnt", 32'(done_cnt), 32'(m_done % 256));
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (gnt_vld && req[gnt_idx]) begin
        m_busy = 1; m_lock = 1; m_ch = int'(gnt_idx);
      end
    end else if (m_lock) begin
      m_lock = 0; m_beats = 0; m_low = 0;
    end else if (m_fin != 0) begin
      m_busy = 0; m_fin = 0;
    end else if (out_rdy) begin
      m_beats++; m_low = 0;
      if (m_beats == BL) begin
        m_fin = 1; m_done++;
      end
    end else if (!req[m_ch]) begin
      m_fin = 2;
    end else begin
      m_low++;
      if (m_low == TO) m_fin = 2;
    end
  endtask

  int mode;

  initial begin
    rst_n = 1'b0; req = '0; gnt_idx = '0; gnt_vld = 1'b0; out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    mode = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc % 150 == 0) mode = $urandom_range(0, 3);
      req     = 4'($urandom);
      gnt_vld = 1'($urandom);
      gnt_idx = 2'($urandom);
      for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
      if (m_busy && $urandom_range(0, 99) < 97) req[m_ch] = 1'b1;
      case (mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ($urandom_range(0, 9) < 7);
        2: out_rdy = ($urandom_range(0, 9) < 2);
        default: out_rdy = 1'b0;
      endcase
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst_n = 1'b1;
      end
      check_outputs();
      model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grant_burst_ctrl.md
GRANT_BURST_CTRL -- requirements
Module: grant_burst_ctrl

Interface
REQ-001 Parameter DW, 8, data width of each channel and of the output.
REQ-002 Parameter BURST_LEN, 4, beats per burst; legal range 2..16.
REQ-003 Parameter TO_CYCLES, 15, consecutive out_rdy-low cycles in XFER that abort a burst; legal range 1..255.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  4  per-channel request levels; bit i = channel i.
REQ-007 gnt_idx  in  2  grant index from the upstream 4:1 arbiter (0..3).
REQ-008 gnt_vld  in  1  gnt_idx qualifier.
REQ-009 ch_data0..ch_data3  in  DW each  per-channel data.
REQ-010 out_rdy  in  1  downstream ready.
REQ-011 arb_ena  out  1  enable to the upstream arbiter.
REQ-012 ack  out  4  one-hot beat acknowledge to the granted channel.
REQ-013 out_vld  out  1  output beat valid.
REQ-014 out_data  out  DW  output beat data.
REQ-015 out_ch  out  2  channel index of the current burst.
REQ-016 out_last  out  1  marks the final beat of a full-length burst.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 abort  out  1  one-cycle pulse when a burst ends early.
REQ-019 done_cnt  out  8  count of completed full-length bursts; wraps 255->0.

Function
REQ-020 FSM states: IDLE, LOCK, XFER, DONE.
REQ-021 IDLE: arb_ena=1; when gnt_vld=1 and req[gnt_idx]=1, capture gnt_idx into cur_idx and go to LOCK; otherwise stay in IDLE, so an idle-default grant with no request is ignored.
REQ-022 LOCK: lasts exactly one cycle with arb_ena=0; clear beat_cnt and to_cnt; go to XFER.
REQ-023 arb_ena is 0 in LOCK, XFER and DONE.
REQ-024 XFER: out_vld=1, out_ch=cur_idx, out_data=ch_data[cur_idx] (combinational mux, zero latency from channel data).
REQ-025 A beat is accepted when out_vld=1 and out_rdy=1 in the same cycle; ack[cur_idx]=1 in that cycle only; all other ack bits are 0.
REQ-026 On each accepted beat, beat_cnt increments and to_cnt clears.
REQ-027 out_last=1 in XFER when beat_cnt==BURST_LEN-1.
REQ-028 Accepted beat with out_last=1: go to DONE as a normal completion.
REQ-029 In XFER, when req[cur_idx]=0 at a clock edge with no beat accepted, go to DONE as an abort.
REQ-030 In XFER, when out_rdy=0, to_cnt increments; when to_cnt reaches TO_CYCLES-1 with out_rdy still 0, go to DONE as an abort.
REQ-031 Simultaneous events: an accepted beat takes priority over a request drop or timeout in the same cycle; if that beat is the last beat, the burst is a normal completion.
REQ-032 DONE: lasts one cycle and then returns to IDLE; on a normal completion, done_cnt increments; on an abort, abort=1 for exactly this cycle and done_cnt holds.
REQ-033 out_vld, ack and out_last are 0 in IDLE, LOCK and DONE.
REQ-034 Minimum grant-to-first-beat latency is 2 cycles (IDLE->LOCK->XFER).
REQ-035 Minimum burst cycle (IDLE to IDLE) is BURST_LEN+3 cycles.

Reset
REQ-036 rst_n low at any time, including mid-burst, forces state=IDLE and clears cur_idx, beat_cnt, to_cnt and done_cnt.
REQ-037 During reset: arb_ena=1, ack=0, out_vld=0, out_data=0, out_ch=0, out_last=0, busy=0, abort=0, done_cnt=0.
REQ-038 After reset release, the first grant is honoured on the first rising edge at which the REQ-021 condition holds.

Verification
REQ-039 Normal burst: req=0b0100, gnt_idx=2, gnt_vld=1, out_rdy=1, BURST_LEN=4 -> LOCK 1 cycle, then 4 beats with ack=0b0100, out_last on beat 4, done_cnt 0->1, back in IDLE 7 cycles after the grant.
REQ-040 Idle default grant: req=0, gnt_idx=3, gnt_vld=1 -> stays in IDLE, busy=0, arb_ena=1.
REQ-041 Backpressure: out_rdy low for 5 cycles after beat 2 -> out_vld held, out_data tracks ch_data[cur_idx], burst completes with 4 acks total and no abort.
REQ-042 Timeout: out_rdy held 0 for 15 cycles in XFER -> abort pulse, done_cnt unchanged, IDLE on the next cycle.
REQ-043 Request drop: req[1] cleared after beat 1 with out_rdy=0 -> abort, no further ack; a simultaneous last-beat accept with the req drop -> normal completion.
REQ-044 Reset mid-XFER at beat 2 -> all outputs at their reset values immediately; done_cnt=0; next grant starts cleanly at beat 0.
